bitonic_sorter_pipeline: RTL and testbench
==========================================

// Module: bitonic_sorter_pipeline
// PURPOSE
//  Fully pipelined bitonic sorting network for N signed words, one array accepted per clock.
//  Sorts ascending (index 0 = smallest) by default.
//  Standalone datapath block feeding downstream logic that consumes a whole sorted array.
//  No back-pressure: results stream out at the input rate.
// PARAMETERS
//  DATA_W  32  element width, signed two's complement
//  N       8   element count; power of two, >=2; stages S = log2(N)*(log2(N)+1)/2 (S=6 for N=8)
// PORTS
//  clk_i    in   1             single clock, rising edge
//  rst_i    in   1             reset, asynchronous, active-high
//  start_i  in   1             array_i valid this cycle; sampled on rising edge
//  array_i  in   DATA_W x [N]  unpacked signed input array
//  array_o  out  DATA_W x [N]  unpacked signed sorted array, registered
//  valid_o  out  1             one-cycle pulse: array_o newly updated
// BEHAVIOUR
//  Interface
//  - One clock; rst_i is asynchronous, active-high.
//  - Reset values: all stage data regs = 0; all stage valid bits = 0; array_o = all 0; valid_o = 0.
//  Network
//  - Standard bitonic network, S compare-exchange layers.
//  - Phase p=1..log2(N); within a phase, distance d = 2^(p-1) down to 1.
//  - Pair (i, i^d) with i < (i^d):
//    - ascending block if (i & 2^p)==0, else descending;
//    - in the final phase every block is ascending.
//  - Compare is signed, full DATA_W. Equal values are either order; output is identical.
//  Pipeline
//  - Each layer = combinational compare-exchange followed by a register stage, plus a valid bit.
//  - Layer 1 operates directly on array_i; no separate input register.
//  - Stage data and valid advance every clock unconditionally.
//  - Valid bit = start_i for stage 1, previous stage valid otherwise.
//  - Stage S is the output register: array_o loads only when stage S-1 valid (or start_i for S=1).
//  - Otherwise array_o holds its last sorted result.
//  - valid_o = registered stage-S valid.
//  Timing
//  - Latency: start_i=1 at edge k -> sorted array on array_o and valid_o=1 after edge k+S-1
//    (edge k+5 for N=8).
//  - Throughput: back-to-back start_i on consecutive edges produce results on consecutive edges.
//  - Gaps in start_i give gaps in valid_o; array_o holds the last result.
//  Boundary conditions
//  - start_i=X/0 never updates array_o.
//  - rst_i asserted mid-flight: all in-flight arrays discarded immediately (async).
//    After release, the first result comes only from a new start_i.
//  - Extreme values (-2^31, 2^31-1) sort correctly; no overflow, compare only, no arithmetic.
// CONFIGURATION
//  SORT_DESCENDING_EN
//  - Defined: every compare-exchange direction is inverted; array_o is descending
//    (index 0 = largest). Latency and handshake unchanged.
//  - Undefined (default): ascending as above.
// TESTING
//  1 Reset 10ns, then array_i={8,7,6,5,4,3,2,1}, start_i=1 at edge k
//    -> after edge k+5: array_o={1,2,3,4,5,6,7,8}, valid_o=1.
//  2 Next edge k+1: array_i={325,0,-345345,1,325,0,325,8}, start_i held 1
//    -> after edge k+6: array_o={-345345,0,0,1,8,325,325,325}, valid_o=1.
//  3 start_i held 1 with constant input
//    -> valid_o stays 1; array_o stable at the same sorted array.
//  4 start_i=1 for one cycle with {-2^31,2^31-1,0,-1,1,-2^31,2^31-1,0}, then start_i=0
//    -> one valid_o pulse; array_o={-2^31,-2^31,-1,0,0,1,2^31-1,2^31-1}, held afterwards.
//  5 rst_i pulsed 2 cycles after a start
//    -> array_o=0, valid_o=0 immediately; no valid_o until a new start_i.
//  6 With SORT_DESCENDING_EN defined, scenario 1 -> array_o={8,7,6,5,4,3,2,1}.

Source files
------------

// File: rtl/bitonic_sorter_pipeline.sv
// Pipelined bitonic sorting network: N signed words per clock, one register stage per compare-exchange layer.
// Latency S-1 edges after the start_i edge. No backpressure. `define SORT_DESCENDING_EN for descending output.
module bitonic_sorter_pipeline #(
    parameter int DATA_W = 32,
    parameter int N      = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic signed [DATA_W-1:0] array_i [N],
    output logic signed [DATA_W-1:0] array_o [N],
    output logic                     valid_o
);
    localparam int LOG = $clog2(N);
    localparam int S   = LOG * (LOG + 1) / 2;

    function automatic int phase_of(input int layer);
        int idx;
        idx = 0;
        phase_of = 1;
        for (int p = 1; p <= LOG; p++) begin
            for (int j = 0; j < p; j++) begin
                if (idx == layer) phase_of = p;
                idx++;
            end
        end
    endfunction

    function automatic int dist_of(input int layer);
        int idx;
        idx = 0;
        dist_of = 1;
        for (int p = 1; p <= LOG; p++) begin
            for (int j = 0; j < p; j++) begin
                if (idx == layer) dist_of = 1 << (p - 1 - j);
                idx++;
            end
        end
    endfunction

    genvar l;
    generate
        for (l = 0; l < S; l++) begin : lay
            localparam int P = phase_of(l);
            localparam int D = dist_of(l);

            logic signed [DATA_W-1:0] din [N];
            logic signed [DATA_W-1:0] cx  [N];
            logic signed [DATA_W-1:0] q   [N];
            logic                     vin;
            logic                     vld;
            logic                     asc;

            if (l == 0) begin : g_in
                assign din = array_i;
                assign vin = start_i;
            end else begin : g_chain
                assign din = lay[l-1].q;
                assign vin = lay[l-1].vld;
            end

            // Block direction comes from bit P of the lower index; the last phase is always one ascending block.
            always_comb begin
                cx  = din;
                asc = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if ((i & D) == 0) begin
                        asc = (P == LOG) || ((i & (1 << P)) == 0);
`ifdef SORT_DESCENDING_EN
                        asc = !asc;
`endif
                        if (asc ? (din[i] > din[i | D]) : (din[i] < din[i | D])) begin
                            cx[i]     = din[i | D];
                            cx[i | D] = din[i];
                        end
                    end
                end
            end

            if (l < S - 1) begin : g_stage
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        q   <= '{default: '0};
                        vld <= 1'b0;
                    end else begin
                        q   <= cx;
                        vld <= vin;
                    end
                end
            end else begin : g_out
                // Output stage only loads on a valid array so array_o holds the last result across gaps.
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        q   <= '{default: '0};
                        vld <= 1'b0;
                    end else begin
                        vld <= vin;
                        if (vin) q <= cx;
                    end
                end
            end
        end
    endgenerate

    assign array_o = lay[S-1].q;
    assign valid_o = lay[S-1].vld;
endmodule

// File: tb/tb_bitonic_sorter_pipeline.sv
// Scoreboard bench for bitonic_sorter_pipeline: expected sorted arrays queued at start_i, checked at valid_o.
module tb_bitonic_sorter_pipeline;
    localparam int W = 32;
    localparam int N = 8;
    localparam int S = 6;

    typedef struct {
        logic [N*W-1:0] data;
        int             due;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic signed [W-1:0] array_in  [N];
    logic signed [W-1:0] array_out [N];
    logic                valid;

    exp_t           sb[$];
    exp_t           e;
    int             cyc = 0;
    int             tests_run = 0;
    int             tests_failed = 0;
    logic [N*W-1:0] last;
    logic           have_last;

    bitonic_sorter_pipeline #(.DATA_W(W), .N(N)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .array_i(array_in),
        .array_o(array_out),
        .valid_o(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack_arr(input logic signed [W-1:0] a [N]);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = a[i];
        return v;
    endfunction

    function automatic logic [N*W-1:0] model_sort(input logic signed [W-1:0] a [N]);
        logic signed [W-1:0] t [N];
        logic signed [W-1:0] x;
        t = a;
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
`ifdef SORT_DESCENDING_EN
                if (t[j-1] < t[j]) begin
`else
                if (t[j-1] > t[j]) begin
`endif
                    x = t[j-1]; t[j-1] = t[j]; t[j] = x;
                end
            end
        end
        return pack_arr(t);
    endfunction

    task automatic set_arr(input int v [N]);
        for (int i = 0; i < N; i++) array_in[i] = v[i];
    endtask

    task automatic drive(input logic st);
        start = st;
        @(posedge clk);
        cyc++;
        if (st) sb.push_back('{data: model_sort(array_in), due: cyc + S - 1});
        #1;
    endtask

    task automatic test_reset();
        set_arr('{0, 0, 0, 0, 0, 0, 0, 0});
        rst = 1'b1;
        drive(1'b0);
        drive(1'b0);
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got %b want 0", valid);
        end
        tests_run++;
        if (pack_arr(array_out) !== '0) begin
            tests_failed++;
            $display("FAIL reset_array got %h want 0", pack_arr(array_out));
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_back_to_back();
        for (int c = 0; c < S + 4; c++) begin
            if (c == 0) set_arr('{8, 7, 6, 5, 4, 3, 2, 1});
            else if (c == 1) set_arr('{325, 0, -345345, 1, 325, 0, 325, 8});
            else set_arr('{9, 9, 9, 9, 9, 9, 9, 9});
            drive(c < 2);
            if (valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL basic_unexpected_valid cyc=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (pack_arr(array_out) !== e.data || e.due != cyc) begin
                        tests_failed++;
                        $display("FAIL basic_result cyc=%0d got %h want %h due=%0d", cyc, pack_arr(array_out), e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL basic_missing cyc=%0d got valid=0 want valid=1", cyc);
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_hold_constant();
        set_arr('{3, -1, 3, 100, -7, 0, 42, 5});
        for (int c = 0; c < 14 + S; c++) begin
            drive(c < 14);
            if (valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL hold_unexpected_valid cyc=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (pack_arr(array_out) !== e.data || e.due != cyc) begin
                        tests_failed++;
                        $display("FAIL hold_result cyc=%0d got %h want %h due=%0d", cyc, pack_arr(array_out), e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL hold_missing cyc=%0d got valid=0 want valid=1", cyc);
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_extremes_gap();
        have_last = 1'b0;
        set_arr('{-2147483647 - 1, 2147483647, 0, -1, 1, -2147483647 - 1, 2147483647, 0});
        for (int c = 0; c < 12; c++) begin
            drive(c == 0);
            for (int i = 0; i < N; i++) array_in[i] = $urandom;
            if (valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL extreme_unexpected_valid cyc=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (pack_arr(array_out) !== e.data || e.due != cyc) begin
                        tests_failed++;
                        $display("FAIL extreme_result cyc=%0d got %h want %h due=%0d", cyc, pack_arr(array_out), e.data, e.due);
                    end
                    last = e.data;
                    have_last = 1'b1;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL extreme_missing cyc=%0d got valid=0 want valid=1", cyc);
                void'(sb.pop_front());
            end else if (have_last) begin
                tests_run++;
                if (pack_arr(array_out) !== last) begin
                    tests_failed++;
                    $display("FAIL extreme_hold cyc=%0d got %h want %h", cyc, pack_arr(array_out), last);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        set_arr('{50, 40, 30, 20, 10, 0, -10, -20});
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (valid !== 1'b0 || pack_arr(array_out) !== '0) begin
            tests_failed++;
            $display("FAIL midflight_reset got valid=%b array=%h want 0/0", valid, pack_arr(array_out));
        end
        sb.delete();
        @(posedge clk);
        cyc++;
        #2 rst = 1'b0;
        for (int c = 0; c < S + 2; c++) begin
            drive(1'b0);
            tests_run++;
            if (valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midflight_stale cyc=%0d got valid=%b want 0", cyc, valid);
            end
        end
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 48 + S; c++) begin
            for (int i = 0; i < N; i++)
                array_in[i] = (c % 2 == 0) ? $urandom : (W'($urandom_range(0, 6)) - 3);
            drive(c < 48 && $urandom_range(0, 3) != 0);
            if (valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL random_unexpected_valid cyc=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (pack_arr(array_out) !== e.data || e.due != cyc) begin
                        tests_failed++;
                        $display("FAIL random_result cyc=%0d got %h want %h due=%0d", cyc, pack_arr(array_out), e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL random_missing cyc=%0d got valid=0 want valid=1", cyc);
                void'(sb.pop_front());
            end
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL random_drain got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_back_to_back();
        test_hold_constant();
        test_extremes_gap();
        test_reset_midflight();
        test_basic_back_to_back();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
